instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Front-end fetch stage between the multi-word instruction memory and the issue controller. It owns the fetch PC and drives the instruction-memory address. Each accepted cycle it captures one FETCH_WIDTH-wide instruction bundle into a circular queue. It presents up to FETCH_WIDTH oldest instructions, with their PCs, to the issue controller, which consumes a variable count per cycle; a PC redirect flushes the queue and restarts fetch.

## Interface
- FETCH_WIDTH, 8: instructions per fetch bundle and maximum dequeue per cycle.
- DEPTH, 32: queue capacity in instructions; power of two, ≥ 2*FETCH_WIDTH.
- START_PC, 32'h0000_3000: fetch PC after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address of the bundle to fetch; equals the fetch_pc register.
- imem_data  in  [FETCH_WIDTH-1:0][31:0]  words at imem_addr + 4k, valid combinationally in the same cycle.
- redirect_valid  in  1  flush queue and restart fetch.
- redirect_pc  in  32  new fetch PC when redirect_valid=1.
- deq_count  in  $clog2(FETCH_WIDTH+1)  number of head instructions consumed this cycle.
- out_valid  out  [FETCH_WIDTH-1:0]  slot k valid iff k < count.
- out_instr  out  [FETCH_WIDTH-1:0][31:0]  instruction at queue position head+k.
- out_pc  out  [FETCH_WIDTH-1:0][31:0]  PC of that instruction.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State:
  - entry arrays instr[DEPTH] and pc[DEPTH];
  - head and tail pointers, $clog2(DEPTH) bits, wrapping mod DEPTH;
  - count;
  - fetch_pc.
- Reset (async, asserted): fetch_pc=START_PC, head=tail=0, count=0. Resulting outputs: imem_addr=START_PC, out_valid=0. Entry arrays are not reset; out_instr and out_pc are don't-care while their slot is invalid.
- Effective dequeue: deq_eff = min(deq_count, count). Excess requests are silently clamped.
- Enqueue condition: enq = !redirect_valid && (DEPTH - count) ≥ FETCH_WIDTH.
  - Free space uses the pre-dequeue count, so a dequeue does not free space in the same cycle.
- On enqueue:
  - write imem_data[k] to instr[tail+k] and fetch_pc+4k to pc[tail+k], for k=0..FETCH_WIDTH-1, wrapping mod DEPTH;
  - tail += FETCH_WIDTH;
  - fetch_pc += 4*FETCH_WIDTH (32-bit wrap).
- No enqueue: fetch_pc holds and imem_data is ignored.
- Dequeue: head += deq_eff.
- Count update: count_next = count + (enq ? FETCH_WIDTH : 0) - deq_eff.
- Redirect (priority over everything):
  - head=tail=0, count=0, fetch_pc=redirect_pc;
  - no enqueue that cycle; deq_count is ignored.
- Outputs are combinational reads of registered state: out_instr[k]=instr[head+k], out_pc[k]=pc[head+k].
- count never exceeds DEPTH and never underflows. This follows from the enqueue and clamp rules.
- No alignment requirement on fetch_pc beyond word alignment. Bit[1:0] of redirect_pc are forced to 0.

## Timing
- Fetch-to-visible latency is 1 cycle: the bundle at imem_addr in cycle N is on out_* in cycle N+1.
- First cycle after reset release: 0x3000 bundle enqueued; visible the following cycle with count=8.
- Redirect asserted in cycle N:
  - cycle N+1: count=0, out_valid=0, imem_addr=redirect_pc;
  - cycle N+2: redirect_pc bundle visible.
- Steady-state throughput is FETCH_WIDTH instructions/cycle when deq_count=FETCH_WIDTH and count ≤ DEPTH-FETCH_WIDTH.
- Full behaviour (count > DEPTH-FETCH_WIDTH): fetch stalls and imem_addr holds; dequeue still proceeds.
- Reset asserted mid-operation: all state clears immediately; any in-flight bundle is lost.

## Test plan
- Reset, then deq_count=0 for 6 cycles:
  - count steps 8, 16, 24, 32, then holds at 32;
  - imem_addr holds 0x3080;
  - out_pc = 0x3000..0x301C, all out_valid=1.
- Full queue, then deq_count=8 every cycle:
  - count goes 24, then stays 24;
  - out_pc[0] advances by 0x20 each cycle with no gaps;
  - head wraps past entry 31 with correct PC/instruction pairing.
- From count=8, deq_count=3:
  - next cycle count=13 (8+8-3), out_pc[0]=0x300C;
  - out_valid=0xFF, slots continuous into the second bundle.
- Redirect to 0x3404 with deq_count=5 and count=20 in the same cycle:
  - next cycle count=0, out_valid=0, imem_addr=0x3404;
  - cycle after: out_pc[0]=0x3404, out_pc[7]=0x3420.
- From count=2 (a post-redirect state), deq_count=8:
  - clamped to 2; next cycle count=8 (2+8-2);
  - no underflow; pointer alignment checked against a model.
- rst_n pulsed low mid-stream at count=24:
  - out_valid=0 and imem_addr=0x3000 immediately (asynchronously);
  - after release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, enqueues one FETCH_WIDTH bundle per cycle into a
// circular instruction/PC queue and presents the oldest FETCH_WIDTH entries to issue.
module instruction_fetch_queue #(
    parameter int          FETCH_WIDTH = 8,
    parameter int          DEPTH       = 32,
    parameter logic [31:0] START_PC    = 32'h0000_3000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    output logic [31:0]                          imem_addr,
    input  logic [FETCH_WIDTH-1:0][31:0]         imem_data,
    input  logic                                 redirect_valid,
    input  logic [31:0]                          redirect_pc,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]     deq_count,
    output logic [FETCH_WIDTH-1:0]               out_valid,
    output logic [FETCH_WIDTH-1:0][31:0]         out_instr,
    output logic [FETCH_WIDTH-1:0][31:0]         out_pc,
    output logic [$clog2(DEPTH+1)-1:0]           count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] deq_eff;
    logic          enq;
    logic [PW-1:0] wr_idx [FETCH_WIDTH];
    logic [PW-1:0] rd_idx [FETCH_WIDTH];

    always_comb begin
        deq_eff    = (CW'(deq_count) > count_q) ? count_q : CW'(deq_count);
        // Free space is judged on the pre-dequeue occupancy.
        enq        = !redirect_valid && (count_q <= CW'(DEPTH - FETCH_WIDTH));
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc & ~32'h3;
        end else begin
            head_d  = head_q + PW'(deq_eff);
            count_d = count_q - deq_eff;
            if (enq) begin
                tail_d     = tail_q + PW'(FETCH_WIDTH);
                count_d    = count_d + CW'(FETCH_WIDTH);
                fetch_pc_d = fetch_pc_q + 32'(4 * FETCH_WIDTH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= START_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            assign wr_idx[gi]    = tail_q + PW'(gi);
            assign rd_idx[gi]    = head_q + PW'(gi);
            assign out_instr[gi] = instr_q[rd_idx[gi]];
            assign out_pc[gi]    = pc_q[rd_idx[gi]];
            assign out_valid[gi] = CW'(gi) < count_q;
        end
    endgenerate

    // Entry storage carries no reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                instr_q[wr_idx[k]] <= imem_data[k];
                pc_q[wr_idx[k]]    <= fetch_pc_q + 32'(4 * k);
            end
        end
    end

    assign imem_addr = fetch_pc_q;
    assign count     = count_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: fill, stream, partial dequeue,
// redirects, clamp at empty and asynchronous mid-stream reset.
module tb_instruction_fetch_queue;
    localparam int FW = 8;

    logic                clk;
    logic                rst_n;
    logic [31:0]         imem_addr;
    logic [FW-1:0][31:0] imem_data;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic [3:0]          deq_count;
    logic [FW-1:0]       out_valid;
    logic [FW-1:0][31:0] out_instr;
    logic [FW-1:0][31:0] out_pc;
    logic [5:0]          count;

    int n_cmp = 0;
    int n_err = 0;

    instruction_fetch_queue dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_count(deq_count), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: each word is a distinct function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    always_comb begin
        for (int k = 0; k < FW; k++) imem_data[k] = mem_word(imem_addr + 32'(4 * k));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input string tag, input int exp_cnt, input logic [31:0] pc0,
                          input logic [31:0] exp_addr);
        logic [7:0]  mask;
        logic [31:0] epc;
        mask = (exp_cnt >= FW) ? 8'hFF : 8'((1 << exp_cnt) - 1);
        $display("[%0t] %s count=%0d out_valid=%h out_pc0=%h imem_addr=%h",
                 $time, tag, count, out_valid, out_pc[0], imem_addr);
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_valid"}, 32'(out_valid), 32'(mask));
        chk({tag, "_addr"}, imem_addr, exp_addr);
        for (int k = 0; k < FW; k++) begin
            if (k < exp_cnt) begin
                epc = pc0 + 32'(4 * k);
                chk($sformatf("%s_pc%0d", tag, k), out_pc[k], epc);
                chk($sformatf("%s_instr%0d", tag, k), out_instr[k], mem_word(epc));
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        deq_count = 4'd0;
        #2 rst_n = 1'b0;
        repeat (2) step();
        window("reset", 0, 32'h0, 32'h3000);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with no dequeue: 8,16,24,32 then hold at 32.
        deq_count = 4'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            window($sformatf("fill%0d", i), (i < 4) ? 8 * (i + 1) : 32, 32'h3000,
                   (i < 4) ? 32'h3020 + 32'(32 * i) : 32'h3080);
        end

        // Full-rate streaming; head wraps past entry 31 on the fourth cycle.
        deq_count = 4'd8;
        for (int i = 0; i < 6; i++) begin
            step();
            window($sformatf("stream%0d", i), 24, 32'h3020 + 32'(32 * i),
                   32'h3080 + 32'(32 * i));
        end

        // Redirect back to 0x3000, then partial dequeue spanning two bundles.
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        step();
        redirect_valid = 1'b0;
        window("redir0", 0, 32'h0, 32'h3000);
        deq_count = 4'd0;
        step();
        window("refill", 8, 32'h3000, 32'h3020);
        deq_count = 4'd3;
        step();
        window("deq3", 13, 32'h300C, 32'h3040);
        deq_count = 4'd1;
        step();
        window("deq1", 20, 32'h3010, 32'h3060);

        // Redirect wins over a simultaneous dequeue.
        redirect_valid = 1'b1;
        redirect_pc = 32'h3404;
        deq_count = 4'd5;
        step();
        redirect_valid = 1'b0;
        window("redir1", 0, 32'h0, 32'h3404);
        deq_count = 4'd0;
        step();
        window("redir1_vis", 8, 32'h3404, 32'h3424);

        // Unaligned redirect target, then over-request from empty is clamped.
        redirect_valid = 1'b1;
        redirect_pc = 32'h5007;
        step();
        redirect_valid = 1'b0;
        window("redir2", 0, 32'h0, 32'h5004);
        deq_count = 4'd8;
        step();
        window("clamp", 8, 32'h5004, 32'h5024);
        step();
        window("deq8", 8, 32'h5024, 32'h5044);
        deq_count = 4'd0;
        step();
        window("grow16", 16, 32'h5024, 32'h5064);
        step();
        window("grow24", 24, 32'h5024, 32'h5084);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        window("async_rst", 0, 32'h0, 32'h3000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        window("post_rst", 8, 32'h3000, 32'h3020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
